// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and helpers for the cascaded BCD counter.
//   DIGIT_W      width of one BCD digit
//   BCD_MAX      largest legal BCD digit value
//   seg7_decode  BCD digit -> active-low 7-segment pattern {g,f,e,d,c,b,a}
`timescale 1ns/1ps
package bcd_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   // Non-BCD codes blank the digit.
   function automatic logic [6:0] seg7_decode(input logic [DIGIT_W-1:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register of the cascaded counter.
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   step_i         count step for the whole counter this cycle
//   up_dn_i        1 = increment, 0 = decrement
//   clr_i          synchronous clear (highest priority)
//   load_i         synchronous load of load_digit_i (clamped to 9)
//   load_digit_i   digit value to load
//   below_all9_i   all lower digits are 9 (tie 1 for digit 0)
//   below_all0_i   all lower digits are 0 (tie 1 for digit 0)
//   digit_o        current digit value
//   all9_o         this digit and all lower digits are 9
//   all0_o         this digit and all lower digits are 0
`timescale 1ns/1ps
module bcd_digit
   import bcd_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               step_i,
   input  logic               up_dn_i,
   input  logic               clr_i,
   input  logic               load_i,
   input  logic [DIGIT_W-1:0] load_digit_i,
   input  logic               below_all9_i,
   input  logic               below_all0_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               all9_o,
   output logic               all0_o
);

   logic [DIGIT_W-1:0] digit_q, digit_d;

   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = '0;
      end else if (load_i) begin
         digit_d = (load_digit_i > BCD_MAX) ? BCD_MAX : load_digit_i;
      end else if (step_i) begin
         if (up_dn_i) begin
            if (below_all9_i) begin
               digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
            end
         end else if (below_all0_i) begin
            digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;
   assign all9_o  = below_all9_i & (digit_q == BCD_MAX);
   assign all0_o  = below_all0_i & (digit_q == '0);

endmodule

// File: rtl/bcd_counter_nd.sv
// bcd_counter_nd: multi-digit cascaded BCD up/down counter with prescaler.
//   mclk      system clock, rising edge
//   reset     asynchronous active-low reset
//   en        count enable, gates the prescaler
//   up_dn     1 = count up, 0 = count down (sampled on the tick cycle)
//   clr       synchronous clear (beats load)
//   load      synchronous load of load_val, digits >9 clamp to 9
//   load_val  BCD load value, digit 0 in [3:0]
//   cnt       current BCD count, digit 0 least significant
//   tick      one-cycle pulse after each prescaler terminal cycle
//   carry     one-cycle pulse when the count wraps
//   seg, an   active-low segments / digit select; present only when the
//             SEG_SCAN_EN macro is defined
`timescale 1ns/1ps
module bcd_counter_nd
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned DIV      = 50_000_000,
   parameter int unsigned SCAN_DIV = 50_000
) (
   input  logic                      mclk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      up_dn,
   input  logic                      clr,
   input  logic                      load,
   input  logic [DIGIT_W*DIGITS-1:0] load_val,
   output logic [DIGIT_W*DIGITS-1:0] cnt,
   output logic                      tick,
   output logic                      carry
`ifdef SEG_SCAN_EN
   ,
   output logic [6:0]                seg,
   output logic [DIGITS-1:0]         an
`endif
);

   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

   // Illegal parameterisations leave this block empty; it also keeps SCAN_DIV
   // referenced in builds without the scan multiplexer.
   if (DIGITS < 1 || DIGITS > 8 || DIV < 1 || SCAN_DIV < 1) begin : g_bad_params
   end

   // Prescaler
   logic [DivW-1:0] div_q, div_d;
   logic            tick_cycle, step;

   assign tick_cycle = en && (div_q == DivLast);
   assign step       = tick_cycle && !clr && !load;

   always_comb begin
      div_d = div_q;
      if (clr || load) begin
         div_d = '0;
      end else if (en) begin
         div_d = tick_cycle ? '0 : div_q + DivW'(1);
      end
   end

   // Digit chain; chain[i] says every digit below i is 9 (resp. 0).
   logic [DIGITS:0]      all9_chain, all0_chain;
   logic [DIGIT_W-1:0]   digit_val [DIGITS];

   assign all9_chain[0] = 1'b1;
   assign all0_chain[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk_i        (mclk),
         .rst_ni       (reset),
         .step_i       (step),
         .up_dn_i      (up_dn),
         .clr_i        (clr),
         .load_i       (load),
         .load_digit_i (load_val[DIGIT_W*i +: DIGIT_W]),
         .below_all9_i (all9_chain[i]),
         .below_all0_i (all0_chain[i]),
         .digit_o      (digit_val[i]),
         .all9_o       (all9_chain[i+1]),
         .all0_o       (all0_chain[i+1])
      );
      assign cnt[DIGIT_W*i +: DIGIT_W] = digit_val[i];
   end

   // Wrap happens on a step when every digit sits at the rollover value.
   logic tick_q, carry_q, tick_d, carry_d;

   assign tick_d  = step;
   assign carry_d = step && (up_dn ? all9_chain[DIGITS] : all0_chain[DIGITS]);

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         div_q   <= '0;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         tick_q  <= tick_d;
         carry_q <= carry_d;
      end
   end

   assign tick  = tick_q;
   assign carry = carry_q;

`ifdef SEG_SCAN_EN
   localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(DIGITS - 1);

   logic [ScanW-1:0]  scan_q, scan_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;

   // Free-running: independent of en, clr and load.
   always_comb begin
      scan_d = scan_q + ScanW'(1);
      idx_d  = idx_q;
      if (scan_q == ScanLast) begin
         scan_d = '0;
         idx_d  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end
      an_d        = '1;
      an_d[idx_q] = 1'b0;
      seg_d       = seg7_decode(digit_val[idx_q]);
   end

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         scan_q <= '0;
         idx_q  <= '0;
         seg_q  <= 7'h7F;
         an_q   <= '1;
      end else begin
         scan_q <= scan_d;
         idx_q  <= idx_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
`endif

endmodule
